// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: follows the start-light bar up to all-on, times the
// interval from lights-out to the driver's trigger press, flags jump starts
// and malformed light sequences, and keeps the best valid time since reset.
module f1_reaction_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             trigger,
    input  logic             ack,
    output logic [CNT_W-1:0] reaction_time,
    output logic             result_valid,
    output logic             jump_start,
    output logic             seq_error,
    output logic             busy,
    output logic [CNT_W-1:0] best_time,
    output logic             best_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMING = 3'd1,
        S_ALL_ON = 3'd2,
        S_TIMING = 3'd3,
        S_DONE   = 3'd4,
        S_FOUL   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             trig_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reaction_time_q, reaction_time_d;
    logic [CNT_W-1:0] best_time_q, best_time_d;
    logic             best_valid_q, best_valid_d;
    logic             result_valid_q, result_valid_d;
    logic             jump_start_q, jump_start_d;
    logic             seq_error_q, seq_error_d;
    logic             busy_q, busy_d;

    // A held trigger produces a single press: only the rising edge counts.
    logic press;
    logic thermo;
    assign press  = trigger & ~trig_q;
    assign thermo = ((lights & (lights + 8'd1)) == 8'd0);

    // State and registered outputs; reset asserts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            trig_q          <= 1'b0;
            count_q         <= '0;
            reaction_time_q <= '0;
            best_time_q     <= '1;
            best_valid_q    <= 1'b0;
            result_valid_q  <= 1'b0;
            jump_start_q    <= 1'b0;
            seq_error_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            trig_q          <= trigger;
            count_q         <= count_d;
            reaction_time_q <= reaction_time_d;
            best_time_q     <= best_time_d;
            best_valid_q    <= best_valid_d;
            result_valid_q  <= result_valid_d;
            jump_start_q    <= jump_start_d;
            seq_error_q     <= seq_error_d;
            busy_q          <= busy_d;
        end
    end

    // Next-state decision; in the held states ack takes priority over everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lights == 8'h01) state_d = S_ARMING;
            end
            S_ARMING: begin
                if (press)                            state_d = S_FOUL;
                else if (lights == 8'hFF)             state_d = S_ALL_ON;
                else if (!thermo || lights == 8'h00)  state_d = S_ERR;
            end
            S_ALL_ON: begin
                if (press)                  state_d = S_FOUL;
                else if (lights == 8'h00)   state_d = S_TIMING;
                else if (lights != 8'hFF)   state_d = S_ERR;
            end
            S_TIMING: begin
                if (press) state_d = S_DONE;
            end
            S_DONE, S_FOUL, S_ERR: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and flags; flags are derived from the state being entered so
    // they assert on the same edge as the transition.
    always_comb begin
        count_d         = count_q;
        reaction_time_d = reaction_time_q;
        best_time_d     = best_time_q;
        best_valid_d    = best_valid_q;
        case (state_q)
            S_ALL_ON: begin
                if (state_d == S_TIMING) count_d = '0;
            end
            S_TIMING: begin
                if (press) begin
                    reaction_time_d = count_q;
                    if (!best_valid_q || count_q < best_time_q) begin
                        best_time_d  = count_q;
                        best_valid_d = 1'b1;
                    end
                end else if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        result_valid_d = (state_d == S_DONE);
        jump_start_d   = (state_d == S_FOUL);
        seq_error_d    = (state_d == S_ERR);
        busy_d         = (state_d == S_ARMING) || (state_d == S_ALL_ON) ||
                         (state_d == S_TIMING);
    end

    assign reaction_time = reaction_time_q;
    assign result_valid  = result_valid_q;
    assign jump_start    = jump_start_q;
    assign seq_error     = seq_error_q;
    assign busy          = busy_q;
    assign best_time     = best_time_q;
    assign best_valid    = best_valid_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: a 16-bit and a 4-bit instance see
// identical stimulus; expected events are queued when stimulus is issued and
// popped by per-instance monitors when a flag rises.
module tb_f1_reaction_timer;

    localparam int K_DONE = 1;
    localparam int K_FOUL = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [15:0] rt;
        logic [15:0] best;
        logic        bv;
    } exp_t;

    logic        clk, rst, trigger, ack;
    logic [7:0]  lights;

    logic [15:0] rt16, best16;
    logic        rv16, js16, se16, busy16, bv16;
    logic [3:0]  rt4, best4;
    logic        rv4, js4, se4, busy4, bv4;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;
    logic [2:0] p16, p4;

    logic [15:0] m_rt16, m_best16;
    logic [3:0]  m_rt4, m_best4;
    logic        m_bv;

    f1_reaction_timer #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .lights(lights), .trigger(trigger), .ack(ack),
        .reaction_time(rt16), .result_valid(rv16), .jump_start(js16),
        .seq_error(se16), .busy(busy16), .best_time(best16), .best_valid(bv16)
    );

    f1_reaction_timer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .lights(lights), .trigger(trigger), .ack(ack),
        .reaction_time(rt4), .result_valid(rv4), .jump_start(js4),
        .seq_error(se4), .busy(busy4), .best_time(best4), .best_valid(bv4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_evt(input string tag, input exp_t e, input logic [3:0] flags,
                           input logic [15:0] rt, input logic [15:0] best, input logic bv);
        logic [3:0] ef;
        ef = (e.kind == K_DONE) ? 4'b1000 : (e.kind == K_FOUL) ? 4'b0100 : 4'b0010;
        $display("%s event kind=%0d flags=%b rt=%0d best=%0h bv=%0b", tag, e.kind, flags, rt, best, bv);
        chk({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
        chk({tag, "_rt"}, {16'd0, rt}, {16'd0, e.rt});
        chk({tag, "_best"}, {16'd0, best}, {16'd0, e.best});
        chk({tag, "_bv"}, {31'd0, bv}, {31'd0, e.bv});
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            p16 <= 3'b000;
        end else begin
            if (({rv16, js16, se16} & ~p16) != 3'b000) begin
                if (q16.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL d16_unexpected: flags=%b with no expected event", {rv16, js16, se16});
                end else begin
                    e16 = q16.pop_front();
                    cmp_evt("d16", e16, {rv16, js16, se16, busy16}, rt16, best16, bv16);
                end
            end
            p16 <= {rv16, js16, se16};
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            p4 <= 3'b000;
        end else begin
            if (({rv4, js4, se4} & ~p4) != 3'b000) begin
                if (q4.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL d4_unexpected: flags=%b with no expected event", {rv4, js4, se4});
                end else begin
                    e4 = q4.pop_front();
                    cmp_evt("d4", e4, {rv4, js4, se4, busy4}, {12'd0, rt4}, {12'd0, best4}, bv4);
                end
            end
            p4 <= {rv4, js4, se4};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_flag(input int kind);
        exp_t e;
        e.kind = kind; e.rt = m_rt16; e.best = m_best16; e.bv = m_bv;
        q16.push_back(e);
        e.rt = {12'd0, m_rt4}; e.best = {12'd0, m_best4};
        q4.push_back(e);
    endtask

    task automatic push_done(input int r);
        logic [15:0] r16;
        logic [3:0]  r4;
        r16 = 16'(r);
        r4  = (r > 15) ? 4'd15 : 4'(r);
        m_rt16 = r16;
        m_rt4  = r4;
        if (!m_bv || r16 < m_best16) m_best16 = r16;
        if (!m_bv || r4 < m_best4)   m_best4  = r4;
        m_bv = 1'b1;
        push_flag(K_DONE);
    endtask

    task automatic model_reset();
        m_rt16 = 16'd0; m_rt4 = 4'd0;
        m_best16 = 16'hFFFF; m_best4 = 4'hF;
        m_bv = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rt16"},  {16'd0, rt16}, 32'd0);
        chk({tag, "_flags16"}, {28'd0, rv16, js16, se16, busy16}, 32'd0);
        chk({tag, "_best16"}, {16'd0, best16}, 32'h0000FFFF);
        chk({tag, "_bv16"},  {31'd0, bv16}, 32'd0);
        chk({tag, "_rt4"},   {28'd0, rt4}, 32'd0);
        chk({tag, "_flags4"}, {28'd0, rv4, js4, se4, busy4}, 32'd0);
        chk({tag, "_best4"}, {28'd0, best4}, 32'h0000000F);
        chk({tag, "_bv4"},   {31'd0, bv4}, 32'd0);
    endtask

    // 01 -> 03 -> ... -> 7F, two cycles per step, then FF held five cycles.
    task automatic run_up();
        lights = 8'h01;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            lights = {lights[6:0], 1'b1};
            tick(2);
        end
        lights = 8'hFF;
        tick(5);
    endtask

    // Lights-out, press r cycles later, then ack back to IDLE.
    task automatic lights_out_press(input int r);
        lights = 8'h00;
        tick(1);
        chk("busy_timing16", {31'd0, busy16}, 32'd1);
        chk("busy_timing4",  {31'd0, busy4},  32'd1);
        tick(r);
        push_done(r);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        $display("run r=%0d acked: rv16=%0b rt16=%0d rv4=%0b rt4=%0d", r, rv16, rt16, rv4, rt4);
        chk("ack_rv16", {31'd0, rv16}, 32'd0);
        chk("ack_rt16", {16'd0, rt16}, {16'd0, m_rt16});
        chk("ack_rv4",  {31'd0, rv4},  32'd0);
        chk("ack_rt4",  {28'd0, rt4},  {28'd0, m_rt4});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; lights = 8'h00; trigger = 1'b0; ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Normal run with reaction 7.
        run_up();
        lights_out_press(7);

        // Jump start while lights=0F.
        lights = 8'h01; tick(2);
        lights = 8'h03; tick(2);
        lights = 8'h07; tick(2);
        lights = 8'h0F; tick(1);
        push_flag(K_FOUL);
        trigger = 1'b1;
        tick(1);
        chk("foul_busy16", {31'd0, busy16}, 32'd0);
        lights = 8'hFF; tick(3);
        lights = 8'h00; tick(3);
        chk("foul_hold16", {31'd0, js16}, 32'd1);
        chk("foul_hold4",  {31'd0, js4},  32'd1);
        trigger = 1'b0;
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("foul_ack16", {28'd0, rv16, js16, se16, busy16}, 32'd0);
        chk("foul_ack4",  {28'd0, rv4, js4, se4, busy4}, 32'd0);

        // Non-thermometer code while arming.
        lights = 8'h01; tick(2);
        lights = 8'h03; tick(2);
        push_flag(K_ERR);
        lights = 8'h05; tick(1);
        chk("err05_busy16", {31'd0, busy16}, 32'd0);
        lights = 8'h00; tick(1);
        ack = 1'b1; tick(1); ack = 1'b0;
        chk("err_ack16", {31'd0, se16}, 32'd0);

        // Bar drops from all-on to 7F.
        run_up();
        push_flag(K_ERR);
        lights = 8'h7F; tick(1);
        chk("err7f_se4", {31'd0, se4}, 32'd1);
        lights = 8'h00; tick(1);
        ack = 1'b1; tick(1); ack = 1'b0;

        // Best tracking and 4-bit saturation.
        run_up(); lights_out_press(12);
        run_up(); lights_out_press(4);
        run_up(); lights_out_press(9);
        chk("best_after3_16", {16'd0, best16}, 32'd4);
        run_up(); lights_out_press(20);

        // Asynchronous reset three cycles into timing.
        run_up();
        lights = 8'h00;
        tick(1);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        trigger = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        // Held trigger must not count as a press: the bar reaches all-on.
        run_up();
        chk("held_trig_js16",   {31'd0, js16},   32'd0);
        chk("held_trig_busy16", {31'd0, busy16}, 32'd1);
        chk("held_trig_busy4",  {31'd0, busy4},  32'd1);
        trigger = 1'b0;
        tick(1);
        lights_out_press(2);

        tick(5);
        chk("q16_drained", q16.size(), 32'd0);
        chk("q4_drained",  q4.size(),  32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
